seg_mux_driver: RTL and testbench
=================================

Name: seg_mux_driver

Overview:
Parametrised, time-multiplexed N-digit seven-segment display driver. Holds a hex word and scans one digit at a time onto a shared segment bus. Inserts a dark guard interval between digits to suppress ghosting. Double-buffers the value so a new word only appears at a frame boundary, which prevents tearing. Sits between a register or counter source and the board display pins.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8).
REFRESH_DIV, 50000, clk cycles each digit is lit (>=2).
DEAD_CYCLES, 4, clk cycles all anodes are off before each digit (>=1).
SEG_ACTIVE_LOW, 0, 0 = segment bit 1 lights the segment; 1 = inverted.
AN_ACTIVE_LOW, 1, 1 = anode enable driven 0 when selected.

Ports:
clk  input  1  sole clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
hex_in  input  4*N_DIGITS  value to display; digit i = hex_in[4i+3:4i]; digit 0 is rightmost.
blank_in  input  N_DIGITS  per-digit force-blank mask, captured with hex_in.
load  input  1  1-cycle strobe; captures hex_in/blank_in into the pending buffer.
seg  output  7  segments {a,b,c,d,e,f,g}, a = MSB; registered.
an  output  N_DIGITS  digit enables, an[i] selects digit i; registered.
frame_start  output  1  1-cycle pulse when the pending buffer commits (start of digit 0).

Behaviour:
- Segment code (active-high form), 0-F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111. Invert all bits when SEG_ACTIVE_LOW=1.
- Buffers:
  - pending (value, mask, valid flag): load=1 writes value and mask and sets valid.
  - active (value, mask): drives the display.
- FSM states are DARK and LIT. A single cycle counter cnt and a digit index d (0..N_DIGITS-1) drive it.
  - DARK: all an deasserted, seg all-off. Stays DEAD_CYCLES cycles, then moves to LIT with cnt=0.
  - LIT: an[d] asserted unless active mask bit d is set (then all an off). seg = code of active digit d, or all-off if blanked. Stays REFRESH_DIV cycles.
  - On LIT exit: d <= (d==N_DIGITS-1) ? 0 : d+1, then go to DARK.
- Commit: on the LIT exit cycle where d wraps N_DIGITS-1 -> 0, if pending valid then active <= pending and valid is cleared.
  - frame_start pulses on that same edge (registered, high for the first DARK cycle of digit 0), and only when a commit occurs.
- Simultaneous load and commit in one cycle: commit takes the pending contents from before the edge; the new load lands in pending with valid=1 and shows next frame.
- Load-to-display latency: from 1 cycle up to one full frame, where frame = N_DIGITS*(DEAD_CYCLES+REFRESH_DIV) cycles.
- seg and an change on the same edge as the FSM state change; there are no combinational paths from inputs to outputs.
- Reset values:
  - state=DARK, cnt=0, d=0.
  - active value=0 and mask=0; pending cleared with valid=0.
  - frame_start=0, all an deasserted, seg all-off (polarity-correct).
- Reset asserted mid-LIT: outputs go dark on the next edge; scanning restarts from DARK, digit 0. A pending load is discarded.
- N_DIGITS=1: d stays 0, and every LIT exit is a frame boundary.

Optional Feature:
SEG_LZB_EN: leading-zero blanking.
- When defined: at commit, every digit above the most significant non-zero digit is additionally blanked (ORed into the active mask). Digit 0 is never zero-blanked, so value 0 shows a single "0".
- When undefined: no zero suppression; only blank_in blanks digits.

Test Plan:
- Reset check (N_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, defaults): hold rst 3 cycles -> seg=0000000, an=1111, frame_start=0; first LIT after release shows an=1110, seg=1111110 (value 0).
- Full scan: load hex_in=16'h1234, blank_in=0 -> after the next frame_start, each digit is lit 4 cycles then dark 1 cycle, in order:
  - an=1110 with seg=0110011 ("4")
  - an=1101 with seg=1111001 ("3")
  - an=1011 with seg=1101101 ("2")
  - an=0111 with seg=0110000 ("1")
  - frame period = 20 cycles.
- Tear-free update: load 16'hABCD while digit 2 is lit -> the rest of that frame still shows 1234; the next frame_start is followed by D, C, B, A codes.
- Load on the commit cycle: load 16'h5555 exactly on the wrap edge with 16'h1111 pending -> this frame shows 1111, the next frame shows 5555, and frame_start pulses on both boundaries.
- Blank mask and reset mid-operation:
  - blank_in=4'b1000 -> digit 3 has an=1111 and seg=0 during its LIT slot.
  - Assert rst during digit 1 LIT -> dark on the next edge, then restart at digit 0 showing 0.
- SEG_LZB_EN defined, load 16'h0042 -> digits 3 and 2 dark, digits 1 and 0 show "4" and "2". Load 16'h0000 -> only digit 0 shows "0".

Source files
------------

// File: rtl/seg_mux_driver.sv
// Purpose : time-multiplexed N-digit seven-segment driver with dark guard interval
//           between digits and frame-boundary double buffering (tear-free updates).
// Latency : load-to-display 1 cycle up to one frame = N_DIGITS*(DEAD_CYCLES+REFRESH_DIV).
// Backpressure: none; load is always accepted, a newer load overwrites the pending word.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   hex_in      display word, digit i = hex_in[4i+3:4i], digit 0 rightmost
//   blank_in    per-digit force-blank mask, captured with hex_in
//   load        1-cycle strobe capturing hex_in/blank_in into the pending buffer
//   seg         registered segments {a,b,c,d,e,f,g}, a = MSB
//   an          registered digit enables, an[i] selects digit i
//   frame_start 1-cycle pulse on the edge where the pending buffer commits
//
// Optional feature macro: SEG_LZB_EN (leading-zero blanking applied at commit).

module seg_mux_driver #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYCLES    = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   hex_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_start
);

    localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0]       DEAD_LAST  = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0]       LIT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0]       LAST_DIGIT = DW'(N_DIGITS - 1);
    // "Off" patterns double as XOR masks that convert active-high forms to pin polarity.
    localparam logic [6:0]          SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF     = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}}
                                                                      : {N_DIGITS{1'b0}};

    typedef enum logic {DARK, LIT} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [DW-1:0]          d;

    logic [4*N_DIGITS-1:0]  pend_val;
    logic [N_DIGITS-1:0]    pend_mask;
    logic                   pend_vld;
    logic [4*N_DIGITS-1:0]  act_val;
    logic [N_DIGITS-1:0]    act_mask;

    logic [3:0]             cur_val;
    logic                   cur_blank;
    logic [N_DIGITS-1:0]    cur_onehot;
    logic [6:0]             lit_seg;
    logic [N_DIGITS-1:0]    lit_an;
    logic [N_DIGITS-1:0]    lz_mask;
    logic [N_DIGITS-1:0]    commit_mask;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'b1111110;
            4'h1: hex2seg = 7'b0110000;
            4'h2: hex2seg = 7'b1101101;
            4'h3: hex2seg = 7'b1111001;
            4'h4: hex2seg = 7'b0110011;
            4'h5: hex2seg = 7'b1011011;
            4'h6: hex2seg = 7'b1011111;
            4'h7: hex2seg = 7'b1110000;
            4'h8: hex2seg = 7'b1111111;
            4'h9: hex2seg = 7'b1111011;
            4'hA: hex2seg = 7'b1110111;
            4'hB: hex2seg = 7'b0011111;
            4'hC: hex2seg = 7'b1001110;
            4'hD: hex2seg = 7'b0111101;
            4'hE: hex2seg = 7'b1001111;
            default: hex2seg = 7'b1000111;
        endcase
    endfunction

    // Select the active digit by comparison rather than variable indexing so the
    // mux stays clean for non-power-of-two digit counts.
    always_comb begin
        cur_val    = 4'h0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (d == DW'(i)) begin
                cur_val       = act_val[4*i +: 4];
                cur_blank     = act_mask[i];
                cur_onehot[i] = 1'b1;
            end
        end
        lit_seg = cur_blank ? SEG_OFF : (hex2seg(cur_val) ^ SEG_OFF);
        lit_an  = cur_blank ? AN_OFF  : (cur_onehot ^ AN_OFF);
    end

`ifdef SEG_LZB_EN
    // A digit is zero-blanked when it and every digit above it are zero.
    // Digit 0 is excluded so an all-zero word still shows one "0".
    logic zero_above;
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (pend_val[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_above;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign commit_mask = pend_mask | lz_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DARK;
            cnt         <= '0;
            d           <= '0;
            pend_val    <= '0;
            pend_mask   <= '0;
            pend_vld    <= 1'b0;
            act_val     <= '0;
            act_mask    <= '0;
            frame_start <= 1'b0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
        end else begin
            frame_start <= 1'b0;
            if (load) begin
                pend_val  <= hex_in;
                pend_mask <= blank_in;
                pend_vld  <= 1'b1;
            end
            case (state)
                DARK: begin
                    if (cnt == DEAD_LAST) begin
                        state <= LIT;
                        cnt   <= '0;
                        seg   <= lit_seg;
                        an    <= lit_an;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LIT: begin
                    if (cnt == LIT_LAST) begin
                        state <= DARK;
                        cnt   <= '0;
                        seg   <= SEG_OFF;
                        an    <= AN_OFF;
                        if (d == LAST_DIGIT) begin
                            d <= '0;
                            // Commit uses pre-edge pending contents; a load on this
                            // same edge stays pending (valid) for the next frame.
                            if (pend_vld) begin
                                act_val     <= pend_val;
                                act_mask    <= commit_mask;
                                frame_start <= 1'b1;
                                if (!load) begin
                                    pend_vld <= 1'b0;
                                end
                            end
                        end else begin
                            d <= d + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= DARK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Purpose : self-checking bench for seg_mux_driver (4 digits, REFRESH_DIV=4, DEAD_CYCLES=1).
// Latency : scoreboard holds committed frames; each frame_start pops one and checks 20 cycles.
// Backpressure: n/a; loads are driven from the main process on negedges.

module tb_seg_mux_driver;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int DC = 1;
    localparam int FRAME = N * (RD + DC);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [15:0]    hex_in = '0;
    logic [3:0]     blank_in = '0;
    logic           load = 1'b0;
    logic [6:0]     seg;
    logic [3:0]     an;
    logic           frame_start;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  mask;
    } frame_t;

    frame_t sbq[$];
    int     checks   = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    seg_mux_driver #(
        .N_DIGITS      (N),
        .REFRESH_DIV   (RD),
        .DEAD_CYCLES   (DC),
        .SEG_ACTIVE_LOW(0),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hex_in     (hex_in),
        .blank_in   (blank_in),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_start(frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] code(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        return t[h];
    endfunction

    function automatic logic blanked(input frame_t f, input int k);
        logic b;
        b = f.mask[k];
`ifdef SEG_LZB_EN
        begin
            int msd;
            msd = 0;
            for (int j = 0; j < N; j++)
                if (f.val[4*j +: 4] != 4'h0) msd = j;
            if (k > msd) b = 1'b1;
        end
`endif
        return b;
    endfunction

    // Expected {frame_start, an, seg} at cycle t of a frame (t=0 is the frame_start cycle).
    function automatic logic [11:0] exp_cycle(input frame_t f, input int t);
        int         k;
        logic [3:0] anv;
        k   = t / (RD + DC);
        anv = 4'b1111;
        if ((t % (RD + DC)) < DC) return {(t == 0), 4'b1111, 7'b0000000};
        if (blanked(f, k)) return {1'b0, 4'b1111, 7'b0000000};
        anv[k] = 1'b0;
        return {1'b0, anv, code(f.val[4*k +: 4])};
    endfunction

    // Scoreboard consumer: every commit must match the oldest outstanding load.
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (!rst && frame_start) begin
                if (sbq.size() == 0) begin
                    check("fs_unexpected", 32'd1, 32'd0);
                end else begin
                    f = sbq.pop_front();
                    for (int t = 0; t < FRAME; t++) begin
                        if (t > 0) @(negedge clk);
                        check($sformatf("frame_%h_t%0d", f.val, t),
                              {20'd0, frame_start, an, seg}, {20'd0, exp_cycle(f, t)});
                    end
                end
            end
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] m, input bit push);
        hex_in   = v;
        blank_in = m;
        load     = 1'b1;
        if (push) sbq.push_back('{val: v, mask: m});
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] v, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== v && n < 3 * FRAME);
        if (an !== v) check({tag, "_timeout"}, {28'd0, an}, {28'd0, v});
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 3 * FRAME);
        if (frame_start !== 1'b1) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_seg", {25'd0, seg}, 32'd0);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first_lit_an", {28'd0, an}, 32'hE);
        check("first_lit_seg", {25'd0, seg}, {25'd0, 7'b1111110});

        // Full scan, then tear-free update loaded while digit 2 is lit
        do_load(16'h1234, 4'b0000, 1'b1);
        wait_fs("fs_1234");
        wait_an(4'b1011, "d2_1234");
        do_load(16'hABCD, 4'b0000, 1'b1);
        wait_fs("fs_abcd");

        // 1111 pending, 5555 loaded on the wrap edge itself
        wait_an(4'b1011, "d2_abcd");
        do_load(16'h1111, 4'b0000, 1'b1);
        wait_an(4'b0111, "d3_abcd");
        repeat (RD - 1) @(negedge clk);
        do_load(16'h5555, 4'b0000, 1'b1);
        check("fs_1111", {31'd0, frame_start}, 32'd1);
        wait_fs("fs_5555");

        // Blank mask on digit 3
        wait_an(4'b1011, "d2_5555");
        do_load(16'h9876, 4'b1000, 1'b1);
        wait_fs("fs_9876");
        repeat (FRAME) @(negedge clk);

        // Pending load discarded by a reset during digit 1 LIT
        do_load(16'h7777, 4'b0000, 1'b0);
        wait_an(4'b1101, "d1_before_rst");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", {28'd0, an}, 32'hF);
        check("midrst_seg", {25'd0, seg}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("restart_an", {28'd0, an}, 32'hE);
        check("restart_seg", {25'd0, seg}, {25'd0, 7'b1111110});
        pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) pulses++;
        end
        check("no_commit_after_rst", pulses, 32'd0);

        // Leading zeros (blanked only when SEG_LZB_EN is defined)
        do_load(16'h0042, 4'b0000, 1'b1);
        wait_fs("fs_0042");
        repeat (FRAME) @(negedge clk);
        do_load(16'h0000, 4'b0000, 1'b1);
        wait_fs("fs_0000");
        repeat (FRAME + 5) @(negedge clk);

        check("sb_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
